fir_out_limiter: RTL
====================

# fir_out_limiter

Output conditioning stage that sits directly downstream of the 5-tap FIR core. It takes the FIR's 32-bit signed accumulator output and rescales it with an arithmetic right shift and round-half-up, then saturates it to a 16-bit signed audio sample. It presents the result on a 2-stage valid/ready pipeline and counts clipping events. An optional peak meter with hold and decay can be compiled in for level display.

## Interface
- `SHIFT`, default 15: right-shift applied to the 32-bit input (legal 1..16).
- `HOLD_CYCLES`, default 1024: cycles the peak meter holds a new maximum before decaying (peak meter builds only).
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: `in_data` is valid this cycle.
- `in_data`, input, 32: signed FIR output sample.
- `in_ready`, output, 1: stage 1 can accept a sample.
- `out_valid`, output, 1: `out_data` holds a sample.
- `out_data`, output, 16: signed rescaled, saturated sample.
- `out_ready`, input, 1: downstream accepts `out_data`.
- `clip`, output, 1: one-cycle pulse when the sample transferred this cycle was saturated.
- `clip_count`, output, 16: number of saturated samples transferred; saturates at 0xFFFF.
- `peak_level`, output, 16: unsigned magnitude of the held peak (peak meter builds only).

## Operation
- Stage 1 (on input transfer, `in_valid && in_ready`):
  - Computes the 33-bit sum `r = sext(in_data) + 2^(SHIFT-1)`.
  - Computes `s1 = r >>> SHIFT` (arithmetic shift), giving round-half-up.
  - Latches `s1` and sets `s1_valid`.
- Stage 2 (when it advances):
  - Saturates `s1` to the range [-32768, 32767].
  - Registers the result into `out_data`, sets `out_valid`, and latches a `sat` flag.
- Advance rule: `adv2 = !out_valid || out_ready`.
  - When `adv2` is true, stage 2 loads from stage 1; if stage 1 is empty, `out_valid` goes to 0.
  - Stage 1 loads when `!s1_valid || adv2`.
  - `in_ready = !s1_valid || adv2`, computed combinationally from registered state and `out_ready`.
- Output transfer is `out_valid && out_ready`. On a transfer where `sat` is set:
  - `clip` = 1 in that same cycle (combinational from `sat` and the transfer).
  - `clip_count` increments on that clock edge, stopping at 0xFFFF.
- No sample is dropped or duplicated under any `out_ready` pattern.
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `clip` = 0, `clip_count` = 0, `peak_level` = 0, stage 1 empty.
- A reset asserted mid-stream discards both stages immediately; no sample emerges afterwards.

## Timing
- Latency is 2 clocks: a sample accepted at edge N appears on `out_data` after edge N+1, i.e. at edge N+2 with `out_ready` held high.
- With `out_ready` held high, throughput is 1 sample/clock.
- `out_ready` low with both stages full gives `in_ready` = 0 in that same cycle.
- Once `out_ready` returns high, `in_ready` returns high in the same cycle.
- Simultaneous input and output transfer with both stages full: stage 2 takes stage 1 and stage 1 takes the new input, with no bubble.
- `out_data` and `out_valid` are held stable while `out_valid && !out_ready`.
- Saturation and rounding boundaries (`SHIFT`=15):
  - `in_data` 16384 gives 1; 16383 gives 0; -16384 gives 0; -16385 gives -1.
  - `in_data` 0x7FFFFFFF gives 32767 with `sat` set.
  - `in_data` 0x80000000 gives -32768 with `sat` set.
  - -32768×32768 gives exactly -32768 with `sat` clear.

## Configuration
- `FIR_LIMITER_PEAK_EN` defined: the peak meter is built.
  - On each output transfer, if |`out_data`| > `peak_level`, load `peak_level` with it (|-32768| clamps to 32767) and reload the hold counter with `HOLD_CYCLES`.
  - Otherwise, while the hold counter is nonzero, it decrements once per clock.
  - Once the hold counter is zero, `peak_level` decreases each clock by `max(peak_level>>4, 1)` until it reaches 0.
  - A load takes precedence over decay in the same cycle.
- `FIR_LIMITER_PEAK_EN` undefined: the meter logic and hold counter are not built, and `peak_level` is tied to 0.

## Test plan
- Reset then a single sample: reset, then `in_data` = 32768000 (1000<<15) with `out_ready` = 1 -> `out_data` = 1000 and `out_valid` high exactly 2 clocks after acceptance; `clip` = 0.
- Rounding sweep: 16384, 16383, -16384, -16385 back-to-back -> outputs 1, 0, 0, -1 on consecutive cycles.
- Saturation: 0x7FFFFFFF then 0x80000000 -> outputs 32767 and -32768, `clip` pulses twice, `clip_count` = 2.
- Backpressure: stream 0..9 (each <<15) with random `out_ready` -> output sequence exactly 0..9; `in_ready` low only when both stages are full and `out_ready` = 0.
- Reset mid-stream: assert `rst` with both stages full -> `out_valid` = 0 and `clip_count` = 0 immediately; nothing is output after release until new input.
- Peak meter (`FIR_LIMITER_PEAK_EN`, `HOLD_CYCLES`=4): one output of 1600 -> `peak_level` = 1600, held for 4 clocks, then 1500, 1407 and so on down to 0.

Source files
------------

// File: rtl/fir_out_limiter.sv
// Rescale (arithmetic shift, round-half-up) and saturate the FIR accumulator into a 16-bit sample,
// over a 2-stage valid/ready pipeline with clip counting. FIR_LIMITER_PEAK_EN builds the peak meter.
module fir_out_limiter #(
  parameter int unsigned SHIFT = 15
`ifdef FIR_LIMITER_PEAK_EN
  , parameter int unsigned HOLD_CYCLES = 1024
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        clip,
  output logic [15:0] clip_count,
  output logic [15:0] peak_level
);

  localparam int unsigned IN_W  = 32;
  localparam int unsigned ACC_W = IN_W + 1;
  localparam int unsigned OUT_W = 16;

  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN    = ACC_W'(-32768);
  localparam logic [OUT_W-1:0]        CNT_MAX    = '1;

  logic signed [ACC_W-1:0] w_round;
  logic signed [ACC_W-1:0] w_scaled;
  logic signed [ACC_W-1:0] r_s1;
  logic                    r_s1_valid;

  logic signed [OUT_W-1:0] w_sat_val;
  logic                    w_sat;
  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_out_valid;
  logic                    r_sat;
  logic [OUT_W-1:0]        r_clip_count;

  logic w_adv2;
  logic w_load1;
  logic w_out_xfer;
  logic w_clip;

  // Pipeline handshake: stage 2 moves when empty or drained, stage 1 when empty or stage 2 moves
  assign w_adv2     = !r_out_valid || out_ready;
  assign w_load1    = !r_s1_valid || w_adv2;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_clip     = w_out_xfer && r_sat;

  // Sign-extend to 33 bits so adding the half-LSB can never overflow
  assign w_round  = {in_data[IN_W-1], in_data} + ROUND_HALF;
  assign w_scaled = w_round >>> SHIFT;

  always_comb begin
    w_sat     = 1'b0;
    w_sat_val = OUT_W'(r_s1);
    if (r_s1 > SAT_MAX) begin
      w_sat     = 1'b1;
      w_sat_val = OUT_W'(SAT_MAX);
    end else if (r_s1 < SAT_MIN) begin
      w_sat     = 1'b1;
      w_sat_val = OUT_W'(SAT_MIN);
    end
  end

  // Stage 1: rounded, shifted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_load1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1 <= w_scaled;
      end
    end
  end

  // Stage 2: saturated output sample and its clip flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat       <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_sat_val;
        r_sat      <= w_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clip_count <= '0;
    end else if (w_clip && (r_clip_count != CNT_MAX)) begin
      r_clip_count <= r_clip_count + OUT_W'(1);
    end
  end

  assign in_ready   = w_load1;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign clip       = w_clip;
  assign clip_count = r_clip_count;

`ifdef FIR_LIMITER_PEAK_EN
  localparam int unsigned HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

  logic [OUT_W-1:0]  w_abs;
  logic [OUT_W-1:0]  w_decay;
  logic [OUT_W-1:0]  r_peak;
  logic [HOLD_W-1:0] r_hold;

  // Magnitude of the transferring sample; -32768 clamps to 32767
  always_comb begin
    w_abs = OUT_W'(r_out_data);
    if (r_out_data == OUT_W'(SAT_MIN)) begin
      w_abs = OUT_W'(SAT_MAX);
    end else if (r_out_data[OUT_W-1]) begin
      w_abs = OUT_W'(-r_out_data);
    end
  end

  always_comb begin
    w_decay = r_peak >> 4;
    if (w_decay == '0) begin
      w_decay = OUT_W'(1);
    end
  end

  // New maximum loads and rearms hold; otherwise hold counts down, then the level decays
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak <= '0;
      r_hold <= '0;
    end else if (w_out_xfer && (w_abs > r_peak)) begin
      r_peak <= w_abs;
      r_hold <= HOLD_W'(HOLD_CYCLES);
    end else if (r_hold != '0) begin
      r_hold <= r_hold - HOLD_W'(1);
    end else if (r_peak != '0) begin
      r_peak <= r_peak - w_decay;
    end
  end

  assign peak_level = r_peak;
`else
  assign peak_level = '0;
`endif

endmodule
